// File: rtl/regfile_selfcheck_pkg.sv
// Shared definitions for the regfile run-and-verify harness: FSM states and
// default geometry.
package regfile_selfcheck_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RST   = 3'd1,
      ST_RUN   = 3'd2,
      ST_SWEEP = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int unsigned DEF_DATA_W     = 32;
   localparam int unsigned DEF_NUM_REGS   = 32;
   localparam int unsigned DEF_REG_ADDR_W = 5;
   localparam int unsigned DEF_CYCLE_W    = 16;
   localparam int unsigned DEF_ERR_W      = 8;

   function automatic logic is_busy(input state_t s);
      return (s == ST_RST) || (s == ST_RUN) || (s == ST_SWEEP);
   endfunction

endpackage

// File: rtl/regfile_selfcheck_if.sv
// Processor/regfile/ROM side-band bundle seen by the self-check harness.
// master = harness, slave = processor + regfile + expected-value ROM.
interface regfile_selfcheck_if #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] proc_rs1;
   logic [REG_ADDR_W-1:0] rf_rs1;
   logic [DATA_W-1:0]     rf_dataA;
   logic                  rwe;
   logic [REG_ADDR_W-1:0] rd;
   logic [REG_ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0]     exp_data;
   logic                  cpu_reset;
   logic                  cpu_stall;
   logic                  test_mode;

   modport master (
      input  proc_rs1, rf_dataA, rwe, rd, exp_data,
      output rf_rs1, exp_addr, cpu_reset, cpu_stall, test_mode
   );

   modport slave (
      output proc_rs1, rf_dataA, rwe, rd, exp_data,
      input  rf_rs1, exp_addr, cpu_reset, cpu_stall, test_mode
   );
endinterface

// File: rtl/regfile_selfcheck_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/regfile_selfcheck.sv
// Run-and-verify harness: resets the CPU, runs it for num_cycles clocks while
// counting register writes, then freezes it and sweeps the regfile against a ROM.
module regfile_selfcheck
   import regfile_selfcheck_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
   parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int unsigned CYCLE_W    = DEF_CYCLE_W,
   parameter int unsigned ERR_W      = DEF_ERR_W
) (
   input  logic                  clock,
   input  logic                  reset,
   regfile_selfcheck_if.master   bus,
   input  logic                  start,
   input  logic [CYCLE_W-1:0]    num_cycles,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_count,
   output logic [CYCLE_W-1:0]    write_count,
   output logic [REG_ADDR_W-1:0] fail_reg,
   output logic [DATA_W-1:0]     fail_exp,
   output logic [DATA_W-1:0]     fail_act
);

   localparam int unsigned SW_W = REG_ADDR_W + 1;
   localparam logic [SW_W-1:0] SWEEP_LAST = SW_W'(NUM_REGS);

   state_t state;
   state_t state_nx;

   logic [CYCLE_W-1:0]    run_len;
   logic [CYCLE_W-1:0]    cyc_cnt;
   logic [SW_W-1:0]       sweep_cnt;
   logic [REG_ADDR_W-1:0] sweep_idx;
   logic [REG_ADDR_W-1:0] cmp_idx;
   logic [DATA_W-1:0]     act_q;

   logic start_ok;
   logic run_last;
   logic sweep_last;
   logic cmp_valid;
   logic mismatch;
   logic err_inc;
   logic wr_inc;
   logic cnt_clr;
   logic test_mode;

   assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign run_last   = (cyc_cnt == (run_len - CYCLE_W'(1)));
   assign sweep_last = (sweep_cnt == SWEEP_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE,
         ST_DONE:  if (start_ok) state_nx = ST_RST;
         ST_RST:   state_nx = (run_len == '0) ? ST_SWEEP : ST_RUN;
         ST_RUN:   if (run_last) state_nx = ST_SWEEP;
         ST_SWEEP: if (sweep_last) state_nx = ST_DONE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Sweep step k presents index k; step k+1 compares the registered read
   // against the ROM word that arrives with one cycle of latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run_len   <= '0;
         cyc_cnt   <= '0;
         sweep_cnt <= '0;
         act_q     <= '0;
      end else begin
         if (start_ok) begin
            run_len <= num_cycles;
         end
         cyc_cnt   <= (state == ST_RUN)   ? cyc_cnt + CYCLE_W'(1) : '0;
         sweep_cnt <= (state == ST_SWEEP) ? sweep_cnt + SW_W'(1)  : '0;
         if (state == ST_SWEEP) begin
            act_q <= bus.rf_dataA;
         end
      end
   end

   assign sweep_idx = sweep_cnt[REG_ADDR_W-1:0];
   assign cmp_idx   = sweep_idx - REG_ADDR_W'(1);
   assign cmp_valid = (state == ST_SWEEP) && (sweep_cnt != '0);
   assign mismatch  = (act_q !== bus.exp_data);
   assign err_inc   = cmp_valid && mismatch;
   assign wr_inc    = (state == ST_RUN) && bus.rwe && (bus.rd != '0);
   assign cnt_clr   = (state == ST_RST);

   // The final compare lands in the same cycle as the move to DONE, so pass
   // folds in this cycle's result rather than waiting for err_count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pass     <= 1'b0;
         fail_reg <= '0;
         fail_exp <= '0;
         fail_act <= '0;
      end else if (state == ST_RST) begin
         pass     <= 1'b0;
         fail_reg <= '0;
         fail_exp <= '0;
         fail_act <= '0;
      end else begin
         if (err_inc && (err_count == '0)) begin
            fail_reg <= cmp_idx;
            fail_exp <= bus.exp_data;
            fail_act <= act_q;
         end
         if ((state == ST_SWEEP) && sweep_last) begin
            pass <= (err_count == '0) && !err_inc;
         end
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (err_inc),
      .clr   (cnt_clr),
      .q     (err_count)
   );

   sat_counter #(.W(CYCLE_W)) u_wr_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (wr_inc),
      .clr   (cnt_clr),
      .q     (write_count)
   );

   assign test_mode     = (state == ST_SWEEP);
   assign bus.test_mode = test_mode;
   assign bus.cpu_reset = (state == ST_RST);
   assign bus.cpu_stall = (state == ST_SWEEP) || (state == ST_DONE);
   assign bus.rf_rs1    = test_mode ? sweep_idx : bus.proc_rs1;
   assign bus.exp_addr  = sweep_idx;
   assign busy          = is_busy(state);
   assign done          = (state == ST_DONE);

endmodule

// File: tb/tb_regfile_selfcheck.sv
// Scoreboard bench for regfile_selfcheck with a behavioural regfile and ROM.
module tb_regfile_selfcheck;
   import regfile_selfcheck_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 16;
   localparam int unsigned EW = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] num_cycles;
   logic          busy, done, pass;
   logic [EW-1:0] err_count;
   logic [CW-1:0] write_count;
   logic [AW-1:0] fail_reg;
   logic [DW-1:0] fail_exp, fail_act;

   regfile_selfcheck_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

   regfile_selfcheck #(
      .DATA_W(DW), .NUM_REGS(NR), .REG_ADDR_W(AW), .CYCLE_W(CW), .ERR_W(EW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .start       (start),
      .num_cycles  (num_cycles),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .err_count   (err_count),
      .write_count (write_count),
      .fail_reg    (fail_reg),
      .fail_exp    (fail_exp),
      .fail_act    (fail_act)
   );

   always #5 clock = ~clock;

   logic [DW-1:0] rf  [NR];
   logic [DW-1:0] rom [NR];

   assign bus.rf_dataA = rf[bus.rf_rs1];
   always @(posedge clock) bus.exp_data <= rom[bus.exp_addr];

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic        exp_pass;
      int unsigned err;
      int unsigned wc;
      int unsigned freg;
      logic [31:0] fexp;
      logic [31:0] fact;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic p, input int unsigned err, input int unsigned wc,
                               input int unsigned freg, input logic [31:0] fexp,
                               input logic [31:0] fact, input int lat);
      exp_t e;
      e.exp_pass = p; e.err = err; e.wc = wc; e.freg = freg;
      e.fexp = fexp; e.fact = fact; e.lat = lat; e.start_cyc = 0;
      return e;
   endfunction

   // Monitor: every rising done retires one scoreboard entry.
   logic done_q = 1'b0;
   exp_t mon_e;
   always @(negedge clock) begin
      if (done && !done_q) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("latency",     64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
            check("pass",        pass,        mon_e.exp_pass);
            check("err_count",   err_count,   64'(mon_e.err));
            check("write_count", write_count, 64'(mon_e.wc));
            check("fail_reg",    fail_reg,    64'(mon_e.freg));
            check("fail_exp",    fail_exp,    mon_e.fexp);
            check("fail_act",    fail_act,    mon_e.fact);
         end
      end
      done_q = done;
   end

   // One run: writes rd=0 twice then rd=3 four times from the first cycle after RST;
   // also writes while idle/RST, which must not count.
   task automatic do_run(input int n, input bit poke, input exp_t e);
      @(negedge clock);
      bus.rwe = 1'b1; bus.rd = 5'd3;
      start = 1'b1; num_cycles = CW'(n);
      e.start_cyc = cyc;
      sb.push_back(e);
      @(negedge clock);
      start = 1'b0;
      check("cpu_reset_on", bus.cpu_reset, 64'd1);
      check("busy_in_rst",  busy,          64'd1);
      @(negedge clock);
      check("cpu_reset_off", bus.cpu_reset, 64'd0);
      check("cpu_stall_after_rst", bus.cpu_stall, (n == 0) ? 64'd1 : 64'd0);
      for (int i = 0; i < 6; i++) begin
         bus.rwe = 1'b1;
         bus.rd  = (i < 2) ? 5'd0 : 5'd3;
         start   = (poke && i == 3);
         @(negedge clock);
      end
      bus.rwe = 1'b0; start = 1'b0;
      for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clock);
      check("done_seen", 64'(sb.size() == 0), 64'd1);
      sb.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; num_cycles = '0;
      bus.rwe = 1'b0; bus.rd = '0; bus.proc_rs1 = 5'd17;
      for (int i = 0; i < NR; i++) begin
         rom[i] = 32'hC0DE_0000 | 32'(i);
         rf[i]  = 32'hC0DE_0000 | 32'(i);
      end
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_busy",      busy,          64'd0);
      check("rst_done",      done,          64'd0);
      check("rst_pass",      pass,          64'd0);
      check("rst_cpu_reset", bus.cpu_reset, 64'd0);
      check("rst_cpu_stall", bus.cpu_stall, 64'd0);
      check("rst_test_mode", bus.test_mode, 64'd0);
      check("rst_err",       err_count,     64'd0);
      check("rst_wc",        write_count,   64'd0);
      check("rst_rf_rs1",    bus.rf_rs1,    64'd17);
      check("rst_exp_addr",  bus.exp_addr,  64'd0);

      // Clean run, start poked mid-RUN: done 1+10+33 clocks after the start edge.
      do_run(10, 1'b1, mk(1'b1, 0, 4, 0, 32'h0, 32'h0, 45));

      // r7 and r9 wrong, restarted from DONE.
      rom[7] = 32'd5; rf[7] = 32'd6;
      rf[9]  = 32'hC0DE_0008;
      do_run(10, 1'b0, mk(1'b0, 2, 4, 7, 32'd5, 32'd6, 45));

      // Zero-length run straight to SWEEP; fail fields cleared.
      rom[7] = 32'hC0DE_0007; rf[7] = 32'hC0DE_0007;
      rf[9]  = 32'hC0DE_0009;
      do_run(0, 1'b0, mk(1'b1, 0, 0, 0, 32'h0, 32'h0, 35));

      // Only the last register wrong: caught on the final sweep step.
      rf[31] = 32'hDEAD_BEEF;
      do_run(1, 1'b0, mk(1'b0, 1, 0, 31, 32'hC0DE_001F, 32'hDEAD_BEEF, 36));

      // Register 0 is part of the sweep.
      rf[31] = 32'hC0DE_001F;
      rf[0]  = 32'h0;
      do_run(3, 1'b0, mk(1'b0, 1, 1, 0, 32'hC0DE_0000, 32'h0, 38));
      rf[0]  = 32'hC0DE_0000;

      // Reset in the middle of SWEEP.
      @(negedge clock);
      start = 1'b1; num_cycles = CW'(2);
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 50 && !bus.test_mode; k++) @(negedge clock);
      check("sweep_entered", bus.test_mode, 64'd1);
      check("sweep_rs1_0",   bus.rf_rs1,    64'd0);
      repeat (3) @(negedge clock);
      check("sweep_rs1_3",   bus.rf_rs1,    64'd3);
      check("sweep_addr_3",  bus.exp_addr,  64'd3);
      #2 reset = 1'b1;
      #1;
      check("abort_test_mode", bus.test_mode, 64'd0);
      check("abort_cpu_stall", bus.cpu_stall, 64'd0);
      check("abort_rf_rs1",    bus.rf_rs1,    64'd17);
      check("abort_busy",      busy,          64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Clean re-run after the abort.
      do_run(10, 1'b1, mk(1'b1, 0, 4, 0, 32'h0, 32'h0, 45));

      repeat (3) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
